// File: rtl/sys_mem_rd_arbiter.sv
// sys_mem_rd_arbiter: N-channel round-robin system-memory read arbiter.
// One transfer in flight at a time. The winning channel's address and length
// are latched and presented to the AXI read master. Returned beats are
// registered and steered to that channel's write strobe.
// Optional feature macro: SYS_MEM_RD_ARB_TIMEOUT_EN adds a per-channel rd_err
// output and a DATA-phase watchdog of C_TIMEOUT beat-less cycles.

// Per-channel handshake/strobe registers, one instance per requester.
module sys_mem_rd_arb_ch (
  input  logic clk_intf,
  input  logic rst,
  input  logic ack_set,   // this channel wins arbitration this cycle
  input  logic own,       // this channel holds the current grant
  input  logic beat,      // accepted beat in DATA
  input  logic cmpl_ev,   // FSM in CMPL
`ifdef SYS_MEM_RD_ARB_TIMEOUT_EN
  input  logic err_ev,    // current transfer ended by the watchdog
  output logic err,
`endif
  output logic ack,
  output logic in_prog,
  output logic cmpl,
  output logic wren
);

  // Every output is registered and pulses are one cycle wide.
  always_ff @(posedge clk_intf) begin
    if (rst) begin
      ack     <= 1'b0;
      in_prog <= 1'b0;
      cmpl    <= 1'b0;
      wren    <= 1'b0;
`ifdef SYS_MEM_RD_ARB_TIMEOUT_EN
      err     <= 1'b0;
`endif
    end else begin
      ack  <= ack_set;
      wren <= own && beat;
      cmpl <= own && cmpl_ev;
`ifdef SYS_MEM_RD_ARB_TIMEOUT_EN
      err  <= own && cmpl_ev && err_ev;
`endif
      if (ack_set)
        in_prog <= 1'b1;
      else if (own && cmpl_ev)
        in_prog <= 1'b0;
    end
  end

endmodule

module sys_mem_rd_arbiter #(
  parameter int C_NUM_CH   = 4,
  parameter int C_ADDR_WTH = 32,
  parameter int C_LEN_WTH  = 16,
  parameter int C_DATA_WTH = 512,
  parameter int C_TIMEOUT  = 1024
) (
  input  logic                             clk_intf,
  input  logic                             rst,
  input  logic [C_NUM_CH-1:0]              rd_req,
  input  logic [C_NUM_CH*C_ADDR_WTH-1:0]   rd_addr,
  input  logic [C_NUM_CH*C_LEN_WTH-1:0]    rd_len,
  output logic [C_NUM_CH-1:0]              rd_req_ack,
  output logic [C_NUM_CH-1:0]              rd_in_prog,
  output logic [C_NUM_CH-1:0]              rd_cmpl,
`ifdef SYS_MEM_RD_ARB_TIMEOUT_EN
  output logic [C_NUM_CH-1:0]              rd_err,
`endif
  output logic                             mst_req,
  output logic [C_ADDR_WTH-1:0]            mst_addr,
  output logic [C_LEN_WTH-1:0]             mst_len,
  input  logic                             mst_ack,
  input  logic                             mst_rd_vld,
  input  logic [C_DATA_WTH-1:0]            mst_rd_data,
  output logic [C_NUM_CH-1:0]              ch_wren,
  output logic [C_DATA_WTH-1:0]            ch_datain
);

  localparam int PW = $clog2(C_NUM_CH);
  localparam logic [C_LEN_WTH-1:0] LEN_ONE = C_LEN_WTH'(1);

  if (C_NUM_CH < 2 || C_TIMEOUT < 2) begin : g_bad_cfg
    $error("sys_mem_rd_arbiter: C_NUM_CH and C_TIMEOUT must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, REQ, DATA, CMPL} state_t;

  typedef struct packed {
    logic [C_ADDR_WTH-1:0] addr;
    logic [C_LEN_WTH-1:0]  len;
  } req_t;

  // Packed views of the flat request buses; channel i lands at index i.
  logic [C_NUM_CH-1:0][C_ADDR_WTH-1:0] addr_a;
  logic [C_NUM_CH-1:0][C_LEN_WTH-1:0]  len_a;
  assign addr_a = rd_addr;
  assign len_a  = rd_len;

  state_t               state_q, state_d;
  req_t                 cur_q;
  logic [PW-1:0]        g_q, ptr_q, win;
  logic                 win_vld;
  logic [C_LEN_WTH-1:0] cnt_q, cnt_nxt;
  logic                 grant_fire, beat_fire, last_beat, cmpl_fire;

  // Round-robin pick: first requester at or above ptr, wrapping.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = 0; i < C_NUM_CH; i++) begin
      int idx;
      idx = int'(ptr_q) + i;
      if (idx >= C_NUM_CH) idx = idx - C_NUM_CH;
      if (!win_vld && rd_req[idx]) begin
        win_vld = 1'b1;
        win     = PW'(idx);
      end
    end
  end

  assign cnt_nxt    = cnt_q + LEN_ONE;
  assign grant_fire = (state_q == IDLE) && win_vld;
  assign beat_fire  = (state_q == DATA) && mst_rd_vld;
  assign last_beat  = beat_fire && (cnt_nxt == cur_q.len);
  assign cmpl_fire  = (state_q == CMPL);

  assign mst_req  = (state_q == REQ);
  assign mst_addr = cur_q.addr;
  assign mst_len  = cur_q.len;

`ifdef SYS_MEM_RD_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(C_TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(C_TIMEOUT - 1);
  logic [WDW-1:0] wd_q;
  logic           wd_hit, err_q;
  // The C_TIMEOUT-th consecutive beat-less DATA cycle ends the transfer.
  assign wd_hit = (state_q == DATA) && !mst_rd_vld && (wd_q == WD_LAST);
`endif

  // FSM state register.
  always_ff @(posedge clk_intf) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (win_vld) state_d = REQ;
      REQ:  if (mst_ack) state_d = (cur_q.len == '0) ? CMPL : DATA;
      DATA: begin
        if (last_beat) state_d = CMPL;
`ifdef SYS_MEM_RD_ARB_TIMEOUT_EN
        else if (wd_hit) state_d = CMPL;
`endif
      end
      CMPL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant latch, beat counter, shared data register and round-robin pointer.
  always_ff @(posedge clk_intf) begin
    if (rst) begin
      g_q       <= '0;
      ptr_q     <= '0;
      cur_q     <= '0;
      cnt_q     <= '0;
      ch_datain <= '0;
    end else begin
      if (grant_fire) begin
        g_q   <= win;
        cur_q <= '{addr: addr_a[win], len: len_a[win]};
        cnt_q <= '0;
      end
      if (beat_fire) begin
        cnt_q     <= cnt_nxt;
        ch_datain <= mst_rd_data;
      end
      if (cmpl_fire)
        ptr_q <= (g_q == PW'(C_NUM_CH - 1)) ? '0 : g_q + PW'(1);
    end
  end

`ifdef SYS_MEM_RD_ARB_TIMEOUT_EN
  // Watchdog restarts on every beat and outside DATA; err_q flags a timed-out transfer.
  always_ff @(posedge clk_intf) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q != DATA || mst_rd_vld) wd_q <= '0;
      else                               wd_q <= wd_q + WDW'(1);
      if (wd_hit)         err_q <= 1'b1;
      else if (cmpl_fire) err_q <= 1'b0;
    end
  end
`endif

  for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
    sys_mem_rd_arb_ch u_ch (
      .clk_intf (clk_intf),
      .rst      (rst),
      .ack_set  (grant_fire && (win == PW'(i))),
      .own      (g_q == PW'(i)),
      .beat     (beat_fire),
      .cmpl_ev  (cmpl_fire),
`ifdef SYS_MEM_RD_ARB_TIMEOUT_EN
      .err_ev   (err_q),
      .err      (rd_err[i]),
`endif
      .ack      (rd_req_ack[i]),
      .in_prog  (rd_in_prog[i]),
      .cmpl     (rd_cmpl[i]),
      .wren     (ch_wren[i])
    );
  end

endmodule

// File: tb/tb_sys_mem_rd_arbiter.sv
// Directed bench for sys_mem_rd_arbiter. Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_sys_mem_rd_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic [N-1:0]            rd_req;
  logic [N-1:0][AW-1:0]    addr_a;
  logic [N-1:0][LW-1:0]    len_a;
  logic [N*AW-1:0]         rd_addr;
  logic [N*LW-1:0]         rd_len;
  logic [N-1:0]            rd_req_ack, rd_in_prog, rd_cmpl, ch_wren;
  logic                    mst_req, mst_ack, mst_rd_vld;
  logic [AW-1:0]           mst_addr;
  logic [LW-1:0]           mst_len;
  logic [DW-1:0]           mst_rd_data, ch_datain;
`ifdef SYS_MEM_RD_ARB_TIMEOUT_EN
  logic [N-1:0]            rd_err;
`endif

  assign rd_addr = addr_a;
  assign rd_len  = len_a;

  sys_mem_rd_arbiter #(
    .C_NUM_CH(N), .C_ADDR_WTH(AW), .C_LEN_WTH(LW), .C_DATA_WTH(DW), .C_TIMEOUT(TO)
  ) dut (
    .clk_intf    (clk),
    .rst         (rst),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_len      (rd_len),
    .rd_req_ack  (rd_req_ack),
    .rd_in_prog  (rd_in_prog),
    .rd_cmpl     (rd_cmpl),
`ifdef SYS_MEM_RD_ARB_TIMEOUT_EN
    .rd_err      (rd_err),
`endif
    .mst_req     (mst_req),
    .mst_addr    (mst_addr),
    .mst_len     (mst_len),
    .mst_ack     (mst_ack),
    .mst_rd_vld  (mst_rd_vld),
    .mst_rd_data (mst_rd_data),
    .ch_wren     (ch_wren),
    .ch_datain   (ch_datain)
  );

  int nvec = 0;
  int nmis = 0;
  logic [DW-1:0] last_data;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] beat_data(input int ch, input int b);
    return DW'(32'hA000_0000 | (ch << 8) | b);
  endfunction

  // Full transfer on channel ch: requests must already be driven. The
  // channel's addr/len are scrambled after the grant to show they are latched.
  task automatic run_xfer(input int ch, input logic [N-1:0] drop, input bit stray);
    logic [AW-1:0] a;
    logic [LW-1:0] l;
    logic [N-1:0]  oh;
    a = addr_a[ch];
    l = len_a[ch];
    oh = '0;
    oh[ch] = 1'b1;
    tick();
    chk("ack", rd_req_ack, oh);
    chk("in_prog_set", rd_in_prog, oh);
    chk("mst_req", mst_req, 1);
    chk("mst_addr", mst_addr, a);
    chk("mst_len", mst_len, l);
    rd_req = rd_req & ~drop;
    addr_a[ch] = ~a;
    len_a[ch] = l + 3;
    if (stray) begin
      mst_rd_vld = 1'b1;
      mst_rd_data = '1;
      tick();
      chk("stray_req_wren", ch_wren, 0);
      chk("stray_req_data", ch_datain, last_data);
      chk("ack_1cyc", rd_req_ack, 0);
      chk("mst_req_hold", mst_req, 1);
      chk("mst_addr_hold", mst_addr, a);
      mst_rd_vld = 1'b0;
    end
    mst_ack = 1'b1;
    tick();
    mst_ack = 1'b0;
    chk("mst_req_drop", mst_req, 0);
    chk("ack_clr", rd_req_ack, 0);
    for (int b = 0; b < int'(l); b++) begin
      mst_rd_vld = 1'b1;
      mst_rd_data = beat_data(ch, b);
      tick();
      last_data = beat_data(ch, b);
      chk("wren", ch_wren, oh);
      chk("datain", ch_datain, last_data);
    end
    mst_rd_vld = 1'b0;
    if (l == 0) chk("zero_len_wren", ch_wren, 0);
    chk("cmpl_early", rd_cmpl, 0);
    chk("in_prog_cmpl", rd_in_prog, oh);
    tick();
    chk("cmpl", rd_cmpl, oh);
    chk("in_prog_drop", rd_in_prog, 0);
    chk("wren_idle", ch_wren, 0);
    addr_a[ch] = a;
    len_a[ch] = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rd_req = '0;
    addr_a = '0;
    len_a = '0;
    mst_ack = 1'b0;
    mst_rd_vld = 1'b0;
    mst_rd_data = '0;
    last_data = '0;
    tick();
    tick();
    chk("rst_ack", rd_req_ack, 0);
    chk("rst_in_prog", rd_in_prog, 0);
    chk("rst_cmpl", rd_cmpl, 0);
    chk("rst_wren", ch_wren, 0);
    chk("rst_mst_req", mst_req, 0);
    chk("rst_mst_addr", mst_addr, 0);
    chk("rst_datain", ch_datain, 0);
    rst = 1'b0;

    // Stray beats in IDLE are dropped.
    mst_rd_vld = 1'b1;
    mst_rd_data = 32'hDEAD_0001;
    tick();
    chk("stray_idle_wren", ch_wren, 0);
    tick();
    chk("stray_idle_data", ch_datain, 0);
    mst_rd_vld = 1'b0;

    // Fairness: all four held, len=1 each; grants 0,1,2,3,0.
    for (int i = 0; i < N; i++) begin
      addr_a[i] = 32'h100 * (i + 1);
      len_a[i] = 16'd1;
    end
    rd_req = 4'b1111;
    run_xfer(0, 4'b0000, 1'b0);
    run_xfer(1, 4'b0000, 1'b0);
    run_xfer(2, 4'b0000, 1'b0);
    run_xfer(3, 4'b0000, 1'b0);
    run_xfer(0, 4'b1111, 1'b0);

    // Single request ch0, len 4, with stray beat and mst_ack stall in REQ.
    addr_a[0] = 32'h1000;
    len_a[0] = 16'd4;
    rd_req = 4'b0001;
    run_xfer(0, 4'b0001, 1'b1);

    // Zero length on ch2.
    len_a[2] = 16'd0;
    rd_req = 4'b0100;
    run_xfer(2, 4'b0100, 1'b0);

    // Reset mid-transfer on ch1 after three of eight beats (ptr=3 before).
    addr_a[1] = 32'h2000;
    len_a[1] = 16'd8;
    rd_req = 4'b0010;
    tick();
    chk("rm_ack", rd_req_ack, 4'b0010);
    rd_req = '0;
    mst_ack = 1'b1;
    tick();
    mst_ack = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mst_rd_vld = 1'b1;
      mst_rd_data = beat_data(1, b);
      tick();
      chk("rm_wren", ch_wren, 4'b0010);
    end
    rst = 1'b1;
    mst_rd_data = 32'hBEEF_0003;
    tick();
    chk("rm_in_prog", rd_in_prog, 0);
    chk("rm_cmpl", rd_cmpl, 0);
    chk("rm_wren0", ch_wren, 0);
    chk("rm_mst_req", mst_req, 0);
    chk("rm_mst_addr", mst_addr, 0);
    chk("rm_mst_len", mst_len, 0);
    chk("rm_datain", ch_datain, 0);
    rst = 1'b0;
    last_data = '0;
    for (int b = 0; b < 2; b++) begin
      tick();
      chk("rm_late_wren", ch_wren, 0);
      chk("rm_late_cmpl", rd_cmpl, 0);
    end
    mst_rd_vld = 1'b0;

    // ptr restarted at 0: ch1 beats ch3, then ch3 follows.
    addr_a[1] = 32'h3000;
    len_a[1] = 16'd2;
    addr_a[3] = 32'h4000;
    len_a[3] = 16'd1;
    rd_req = 4'b1010;
    run_xfer(1, 4'b0010, 1'b0);
    run_xfer(3, 4'b1000, 1'b0);

`ifdef SYS_MEM_RD_ARB_TIMEOUT_EN
    begin
      int n;
      addr_a[0] = 32'h5000;
      len_a[0] = 16'd4;
      rd_req = 4'b0001;
      tick();
      chk("to_ack", rd_req_ack, 4'b0001);
      rd_req = '0;
      mst_ack = 1'b1;
      tick();
      mst_ack = 1'b0;
      for (int b = 0; b < 2; b++) begin
        mst_rd_vld = 1'b1;
        mst_rd_data = beat_data(0, b);
        tick();
        chk("to_wren", ch_wren, 4'b0001);
      end
      mst_rd_vld = 1'b0;
      n = 0;
      while (n < 40 && rd_cmpl == 0) begin
        tick();
        n++;
      end
      chk("to_cmpl", rd_cmpl, 4'b0001);
      chk("to_err", rd_err, 4'b0001);
      chk("to_window", (n >= TO && n <= TO + 3), 1);
      mst_rd_vld = 1'b1;
      tick();
      chk("to_late_wren", ch_wren, 0);
      chk("to_err_clr", rd_err, 0);
      mst_rd_vld = 1'b0;
      addr_a[1] = 32'h6000;
      len_a[1] = 16'd1;
      rd_req = 4'b0011;
      run_xfer(1, 4'b0011, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
